fusion_seq: RTL and testbench

FUSION_SEQ -- requirements
Module: fusion_seq

---
 rtl/fusion_pkg.sv | 34 +++
 rtl/fusion_unit.sv | 48 ++++
 rtl/fusion_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fusion_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// rtl/fusion_pkg.sv - shared constants, state type and operand helper for fusion_seq
// Purpose: product latency, precision codes, sequencer state enum and the
//          operand widening rule used by fusion_unit.
// Ports: none (package).
package fusion_pkg;

  // Cycles from an operand pair entering fusion_unit to its psum_fwd
  localparam int FU_LAT = 2;

  // Precision codes carried on cfg_in_width / cfg_weight_width
  localparam logic [2:0] W4 = 3'b100;
  localparam logic [2:0] W2 = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widen a 4-bit operand field to 6 bits. In 2-bit mode only the low two
  // bits are meaningful; anything other than W2 is treated as 4-bit.
  function automatic logic [5:0] ext_operand(input logic [3:0] v,
                                             input logic [2:0] width,
                                             input logic       sgn);
    logic [5:0] r;
    if (width == W2)
      r = sgn ? {{4{v[1]}}, v[1:0]} : {4'b0000, v[1:0]};
    else
      r = sgn ? {{2{v[3]}}, v} : {2'b00, v};
    return r;
  endfunction

endpackage

// File: rtl/fusion_unit.sv
// rtl/fusion_unit.sv - two-stage precision-configurable multiplier
// Purpose: multiplies one in_data/weight pair per cycle at 4-bit or 2-bit
//          precision, signed or unsigned per operand, result after FU_LAT cycles.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_data, weight [3:0]     operand fields
//   in_width, weight_width    precision codes (W4 / W2)
//   s_in, s_weight            per-operand signedness
//   psum_fwd [7:0]            registered product, low 8 bits
module fusion_unit
  import fusion_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic [3:0] weight,
  input  logic [2:0] in_width,
  input  logic [2:0] weight_width,
  input  logic       s_in,
  input  logic       s_weight,
  output logic [7:0] psum_fwd
);

  logic [5:0] a_q;
  logic [5:0] b_q;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] prod;

  // The low 8 bits of a product depend only on the low 8 bits of the
  // sign-extended operands, so an 8x8 multiply is sufficient.
  assign a8   = {{2{a_q[5]}}, a_q};
  assign b8   = {{2{b_q[5]}}, b_q};
  assign prod = a8 * b8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      psum_fwd <= '0;
    end else begin
      a_q      <= ext_operand(in_data, in_width, s_in);
      b_q      <= ext_operand(weight, weight_width, s_weight);
      psum_fwd <= prod;
    end
  end

endmodule

// File: rtl/fusion_seq.sv
// rtl/fusion_seq.sv - job sequencer streaming operand pairs into fusion_unit and accumulating
// Purpose: latches a job configuration on start, accepts cfg_len operand pairs
//          at up to one per cycle, accumulates the products and presents the sum
//          on a valid/ready result port. Optional macro FUSION_SEQ_SAT_EN makes
//          the accumulator saturate and adds res_sat.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start, cfg_len                  job start pulse and pair count
//   cfg_in_width, cfg_weight_width  precision codes
//   cfg_s_in, cfg_s_weight          signedness flags
//   op_valid/op_ready/op_in/op_weight   operand stream
//   res_valid/res_ready/res_data    result handshake
//   busy                            high outside IDLE
//   res_sat                         clamp occurred (FUSION_SEQ_SAT_EN only)
module fusion_seq
  import fusion_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [2:0]       cfg_in_width,
  input  logic [2:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_in,
  input  logic [3:0]       op_weight,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
`ifdef FUSION_SEQ_SAT_EN
  ,
  output logic             res_sat
`endif
);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [2:0]         in_w_q;
  logic [2:0]         wt_w_q;
  logic               s_in_q;
  logic               s_wt_q;
  logic [FU_LAT-1:0]  vpipe;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   psum_ext;
  logic [7:0]         psum_fwd;
  logic [3:0]         fu_in;
  logic [3:0]         fu_weight;
  logic               xfer;
  logic               signed_job;

  // op_ready is registered and only ever high in RUN
  assign xfer       = op_valid & op_ready;
  assign fu_in      = xfer ? op_in : 4'd0;
  assign fu_weight  = xfer ? op_weight : 4'd0;
  assign signed_job = s_in_q | s_wt_q;
  assign psum_ext   = signed_job ? {{(ACC_W-8){psum_fwd[7]}}, psum_fwd}
                                 : {{(ACC_W-8){1'b0}}, psum_fwd};

  fusion_unit u_fusion_unit (
    .clk          (clk),
    .rst          (rst),
    .in_data      (fu_in),
    .weight       (fu_weight),
    .in_width     (in_w_q),
    .weight_width (wt_w_q),
    .s_in         (s_in_q),
    .s_weight     (s_wt_q),
    .psum_fwd     (psum_fwd)
  );

`ifdef FUSION_SEQ_SAT_EN
  logic [ACC_W:0] sum_x;
  logic           clamp;
  logic           sat_q;

  // One guard bit detects overflow; signed jobs clamp toward the sign of
  // the overflowed sum, unsigned jobs can only overflow upward.
  always_comb begin
    sum_x    = '0;
    clamp    = 1'b0;
    acc_next = '0;
    if (signed_job) begin
      sum_x = {acc[ACC_W-1], acc} + {psum_ext[ACC_W-1], psum_ext};
      if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
        clamp    = 1'b1;
        acc_next = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = sum_x[ACC_W-1:0];
      end
    end else begin
      sum_x = {1'b0, acc} + {1'b0, psum_ext};
      if (sum_x[ACC_W]) begin
        clamp    = 1'b1;
        acc_next = '1;
      end else begin
        acc_next = sum_x[ACC_W-1:0];
      end
    end
  end
`else
  assign acc_next = acc + psum_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res_data  <= '0;
      acc       <= '0;
      cnt       <= '0;
      vpipe     <= '0;
      len_q     <= '0;
      in_w_q    <= '0;
      wt_w_q    <= '0;
      s_in_q    <= 1'b0;
      s_wt_q    <= 1'b0;
`ifdef FUSION_SEQ_SAT_EN
      sat_q     <= 1'b0;
      res_sat   <= 1'b0;
`endif
    end else begin
      // vpipe[FU_LAT-1] marks that psum_fwd carries a real product this cycle
      vpipe <= {vpipe[FU_LAT-2:0], xfer};
      if (vpipe[FU_LAT-1]) begin
        acc <= acc_next;
`ifdef FUSION_SEQ_SAT_EN
        sat_q <= sat_q | clamp;
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= cfg_len;
            in_w_q <= cfg_in_width;
            wt_w_q <= cfg_weight_width;
            s_in_q <= cfg_s_in;
            s_wt_q <= cfg_s_weight;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef FUSION_SEQ_SAT_EN
            sat_q  <= 1'b0;
`endif
            if (cfg_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= '0;
`ifdef FUSION_SEQ_SAT_EN
              res_sat   <= 1'b0;
`endif
            end else begin
              state    <= RUN;
              op_ready <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            cnt <= cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == len_q) begin
              state    <= DRAIN;
              op_ready <= 1'b0;
            end
          end
        end

        DRAIN: begin
          // Empty pipe means the last product was added on the previous edge
          if (vpipe == '0) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= acc;
`ifdef FUSION_SEQ_SAT_EN
            res_sat   <= sat_q;
`endif
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_seq.sv
// tb/tb_fusion_seq.sv - self-checking bench for fusion_seq (table vectors, corner sequences, random jobs)
module tb_fusion_seq;

`ifdef FUSION_SEQ_SAT_EN
  localparam int ACC_W = 12;
`else
  localparam int ACC_W = 16;
`endif
  localparam int LEN_W = 8;
  localparam int LAT   = 2;
  localparam logic [2:0] C4 = 3'b100;
  localparam logic [2:0] C2 = 3'b010;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [2:0]       cfg_in_width = '0;
  logic [2:0]       cfg_weight_width = '0;
  logic             cfg_s_in = 1'b0;
  logic             cfg_s_weight = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [3:0]       op_in = '0;
  logic [3:0]       op_weight = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [ACC_W-1:0] res_data;
  logic             busy;
`ifdef FUSION_SEQ_SAT_EN
  logic             res_sat;
`endif

  always #5 clk = ~clk;

  fusion_seq #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_len          (cfg_len),
    .cfg_in_width     (cfg_in_width),
    .cfg_weight_width (cfg_weight_width),
    .cfg_s_in         (cfg_s_in),
    .cfg_s_weight     (cfg_s_weight),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_in            (op_in),
    .op_weight        (op_weight),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .busy             (busy)
`ifdef FUSION_SEQ_SAT_EN
    ,
    .res_sat          (res_sat)
`endif
  );

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  int  ins_arr[256];
  int  wts_arr[256];
  int  lat_seen;
  bit  rdy_ok;

  typedef struct {
    int         len;
    logic [2:0] iw;
    logic [2:0] ww;
    bit         si;
    bit         sw;
    logic [31:0] in_nib;
    logic [31:0] wt_nib;
    int         gap;
    int         exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint mask_acc(input longint v);
    return v & ((64'sd1 <<< ACC_W) - 1);
  endfunction

  // Value of an operand field at its configured precision
  function automatic int opval(input int v, input logic [2:0] w, input bit s);
    int bits;
    int x;
    bits = (w == C2) ? 2 : 4;
    x = v & ((1 << bits) - 1);
    if (s && x >= (1 << (bits - 1))) x = x - (1 << bits);
    return x;
  endfunction

  // Expected result for pairs 0..len-1 held in ins_arr/wts_arr
  function automatic longint model(input int len, input logic [2:0] iw, input logic [2:0] ww,
                                   input bit si, input bit sw, output bit sat);
    longint total;
    longint p;
    total = 0;
    sat = 1'b0;
    for (int i = 0; i < len; i++) begin
      p = longint'(opval(ins_arr[i], iw, si) * opval(wts_arr[i], ww, sw));
      p = p & 255;
      if ((si || sw) && p >= 128) p = p - 256;
      total = total + p;
`ifdef FUSION_SEQ_SAT_EN
      if (si || sw) begin
        if (total > (64'sd1 <<< (ACC_W-1)) - 1) begin total = (64'sd1 <<< (ACC_W-1)) - 1; sat = 1'b1; end
        if (total < -(64'sd1 <<< (ACC_W-1)))    begin total = -(64'sd1 <<< (ACC_W-1));    sat = 1'b1; end
      end else if (total > (64'sd1 <<< ACC_W) - 1) begin
        total = (64'sd1 <<< ACC_W) - 1;
        sat = 1'b1;
      end
`endif
    end
    return mask_acc(total);
  endfunction

  // gap: 0 back-to-back, 1 op_valid toggles, 2 random op_valid.
  // abort: return right after the last transfer without waiting for the result.
  task automatic do_job(input int len, input logic [2:0] iw, input logic [2:0] ww,
                        input bit si, input bit sw, input int gap, input bit abort);
    int i;
    int guard;
    bit v;
    bit ph;
    i = 0;
    guard = 0;
    ph = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cfg_len = LEN_W'(len);
    cfg_in_width = iw;
    cfg_weight_width = ww;
    cfg_s_in = si;
    cfg_s_weight = sw;
    @(negedge clk);
    // Scramble the config after start: the job must run on the latched copy
    start = 1'b0;
    cfg_len = LEN_W'($urandom);
    cfg_in_width = (iw == C4) ? C2 : C4;
    cfg_weight_width = (ww == C4) ? C2 : C4;
    cfg_s_in = ~si;
    cfg_s_weight = ~sw;
    rdy_ok = 1'b1;
    while (i < len && guard < 2000) begin
      if (!op_ready) rdy_ok = 1'b0;
      if (gap == 0) v = 1'b1;
      else if (gap == 1) v = ph;
      else v = 1'($urandom % 2);
      ph = ~ph;
      op_valid = v;
      op_in = ins_arr[i][3:0];
      op_weight = wts_arr[i][3:0];
      if (v && op_ready) i++;
      @(negedge clk);
      guard++;
    end
    op_valid = 1'b0;
    op_in = 4'd0;
    op_weight = 4'd0;
    if (i < len) $display("FAIL stream_timeout: got %0d pairs expected %0d", i, len);
    lat_seen = 1;
    if (!abort) begin
      while (!res_valid && lat_seen < 50) begin
        @(negedge clk);
        lat_seen++;
      end
    end
  endtask

  task automatic check_job(input string name, input longint exp, input bit exp_sat);
    chk({name, " res_valid"}, longint'(res_valid), 1);
    chk({name, " res_data"}, longint'(res_data), exp);
    chk({name, " latency"}, longint'(lat_seen - 1), LAT + 1);
    chk({name, " op_ready_in_run"}, longint'(rdy_ok), 1);
    chk({name, " busy"}, longint'(busy), 1);
`ifdef FUSION_SEQ_SAT_EN
    chk({name, " res_sat"}, longint'(res_sat), longint'(exp_sat));
`else
    if (exp_sat) $display("note: saturation expected without saturation build");
`endif
  endtask

  task automatic finish_job(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, " idle res_valid"}, longint'(res_valid), 0);
    chk({name, " idle busy"}, longint'(busy), 0);
  endtask

  initial begin
    longint exp;
    bit     exp_sat;
    int     len;
    logic [2:0] iw;
    logic [2:0] ww;
    bit     si;
    bit     sw;

    // len, in width, weight width, s_in, s_weight, in nibbles, weight nibbles, gap, expected
    tbl[0] = '{3, C4, C4, 1'b1, 1'b1, 32'h0000_07C3, 32'h0000_075E, 0, 23};
    tbl[1] = '{2, C4, C4, 1'b0, 1'b0, 32'h0000_001F, 32'h0000_002F, 0, 227};
    tbl[2] = '{4, C2, C2, 1'b0, 1'b0, 32'h0000_F5A7, 32'h0000_163B, 1, 20};
    tbl[3] = '{3, C2, C2, 1'b1, 1'b1, 32'h0000_0132, 32'h0000_0312, 0, 2};
    tbl[4] = '{2, C4, C2, 1'b1, 1'b0, 32'h0000_0058, 32'h0000_0023, 1, -14};
    tbl[5] = '{1, C4, C4, 1'b0, 1'b1, 32'h0000_000F, 32'h0000_000F, 0, -15};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset op_ready", longint'(op_ready), 0);
    chk("reset res_valid", longint'(res_valid), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset res_data", longint'(res_data), 0);
    rst = 1'b0;

    // Table vectors
    foreach (tbl[k]) begin
      for (int j = 0; j < 8; j++) begin
        ins_arr[j] = int'(tbl[k].in_nib[4*j +: 4]);
        wts_arr[j] = int'(tbl[k].wt_nib[4*j +: 4]);
      end
      do_job(tbl[k].len, tbl[k].iw, tbl[k].ww, tbl[k].si, tbl[k].sw, tbl[k].gap, 1'b0);
      check_job($sformatf("vec%0d", k), mask_acc(longint'(tbl[k].exp)), 1'b0);
      finish_job($sformatf("vec%0d", k));
    end

    // Zero-length job: DONE straight after start, no op_ready
    @(negedge clk);
    start = 1'b1;
    cfg_len = '0;
    cfg_in_width = C4;
    cfg_weight_width = C4;
    cfg_s_in = 1'b1;
    cfg_s_weight = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0 res_valid", longint'(res_valid), 1);
    chk("len0 res_data", longint'(res_data), 0);
    chk("len0 op_ready", longint'(op_ready), 0);
    finish_job("len0");

    // Backpressure: result held, start ignored while DONE
    ins_arr[0] = 5; wts_arr[0] = 6;
    ins_arr[1] = 3; wts_arr[1] = 2;
    do_job(2, C4, C4, 1'b0, 1'b0, 0, 1'b0);
    check_job("bp", 36, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      cfg_len = 8'd1;
      @(negedge clk);
      chk($sformatf("bp hold%0d res_valid", c), longint'(res_valid), 1);
      chk($sformatf("bp hold%0d res_data", c), longint'(res_data), 36);
      chk($sformatf("bp hold%0d busy", c), longint'(busy), 1);
    end
    start = 1'b0;
    finish_job("bp");

    // Reset in DRAIN: outputs clear at once, aborted job yields nothing
    ins_arr[0] = 7; wts_arr[0] = 7;
    ins_arr[1] = 7; wts_arr[1] = 7;
    ins_arr[2] = 7; wts_arr[2] = 7;
    do_job(3, C4, C4, 1'b1, 1'b1, 0, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort op_ready", longint'(op_ready), 0);
    chk("abort res_valid", longint'(res_valid), 0);
    chk("abort busy", longint'(busy), 0);
    chk("abort res_data", longint'(res_data), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (res_valid || busy) seen++;
      end
      chk("abort no result", longint'(seen), 0);
    end
    ins_arr[0] = 1; wts_arr[0] = 1;
    do_job(1, C4, C4, 1'b0, 1'b0, 0, 1'b0);
    check_job("post_abort", 1, 1'b0);
    finish_job("post_abort");

`ifdef FUSION_SEQ_SAT_EN
    // Signed saturation: 255 x (-8 * -8) clamps at the positive limit
    for (int j = 0; j < 255; j++) begin
      ins_arr[j] = 8;
      wts_arr[j] = 8;
    end
    do_job(255, C4, C4, 1'b1, 1'b1, 0, 1'b0);
    check_job("sat", 2047, 1'b1);
    finish_job("sat");
`endif

    // Random jobs against the reference model
    for (int r = 0; r < 10; r++) begin
      len = 1 + int'($urandom % 12);
      iw = ($urandom % 2) ? C4 : C2;
      ww = ($urandom % 2) ? C4 : C2;
      si = 1'($urandom % 2);
      sw = 1'($urandom % 2);
      for (int j = 0; j < len; j++) begin
        ins_arr[j] = int'($urandom % 16);
        wts_arr[j] = int'($urandom % 16);
      end
      exp = model(len, iw, ww, si, sw, exp_sat);
      do_job(len, iw, ww, si, sw, int'($urandom % 3), 1'b0);
      check_job($sformatf("rand%0d", r), exp, exp_sat);
      finish_job($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
